bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 21 ++
 rtl/bit_serializer.sv | 110 +++++++++++
 tb/tb_bit_serializer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared state constants for the bit serializer and the downstream 1010 sequence detector.
package bit_serializer_pkg;

  localparam logic SER_IDLE  = 1'b0;
  localparam logic SER_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = SER_IDLE,
    StShift = SER_SHIFT
  } ser_state_e;

  // Sequence detector states: named by the prefix of 1010 matched so far.
  localparam logic [2:0] DET_IDLE  = 3'd0;
  localparam logic [2:0] DET_S1    = 3'd1;
  localparam logic [2:0] DET_S10   = 3'd2;
  localparam logic [2:0] DET_S101  = 3'd3;
  localparam logic [2:0] DET_S1010 = 3'd4;

  localparam logic [3:0] DET_PATTERN = 4'b1010;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready upload, downstream stall and word counter.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             stall,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  ser_state_e       r_state, w_state_d;
  logic [WIDTH-1:0] r_shift, w_shift_d;
  logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic             r_dout, w_dout_d;
  logic             r_dout_valid, w_dout_valid_d;
  logic [7:0]       r_words_sent, w_words_sent_d;

  logic             w_last;
  logic             w_accept;
  logic             w_load_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shift_adv;

  // The last-bit cycle doubles as an accept window so words can run back to back.
  assign w_last    = (r_state == StShift) && (r_bit_cnt == LastCnt) && !stall;
  assign din_ready = rst && ((r_state == StIdle) || w_last);
  assign w_accept  = din_valid && din_ready;

  assign w_load_bit  = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign w_next_bit  = (MSB_FIRST != 0) ? r_shift[WIDTH-2] : r_shift[1];
  assign w_shift_adv = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_d      = r_state;
    w_shift_d      = r_shift;
    w_bit_cnt_d    = r_bit_cnt;
    w_dout_d       = r_dout;
    w_dout_valid_d = r_dout_valid;
    w_words_sent_d = r_words_sent;

    unique case (r_state)
      StIdle: begin
        w_dout_d       = 1'b0;
        w_dout_valid_d = 1'b0;
      end
      StShift: begin
        if (stall) begin
          w_dout_valid_d = 1'b0;
        end else if (r_bit_cnt == LastCnt) begin
          w_words_sent_d = r_words_sent + 8'd1;
          w_state_d      = StIdle;
          w_bit_cnt_d    = '0;
          w_dout_d       = 1'b0;
          w_dout_valid_d = 1'b0;
        end else begin
          w_shift_d      = w_shift_adv;
          w_bit_cnt_d    = r_bit_cnt + CntW'(1);
          w_dout_d       = w_next_bit;
          w_dout_valid_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_accept) begin
      w_state_d      = StShift;
      w_shift_d      = din;
      w_bit_cnt_d    = '0;
      w_dout_d       = w_load_bit;
      w_dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_words_sent <= 8'd0;
    end else begin
      r_state      <= w_state_d;
      r_shift      <= w_shift_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_dout       <= w_dout_d;
      r_dout_valid <= w_dout_valid_d;
      r_words_sent <= w_words_sent_d;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == StShift);
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: directed scenarios plus a randomized run against a bit-stream model.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a_din, b_din;
  logic         a_din_valid, b_din_valid, a_stall, b_stall;
  logic         a_din_ready, b_din_ready, a_dout, b_dout;
  logic         a_dout_valid, b_dout_valid, a_busy, b_busy;
  logic [7:0]   a_words_sent, b_words_sent;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_ws_a = 8'd0;
  bit         mon_en   = 1'b0;
  logic       obs[$];

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .stall(a_stall), .dout(a_dout), .dout_valid(a_dout_valid), .busy(a_busy),
    .words_sent(a_words_sent)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .stall(b_stall), .dout(b_dout), .dout_valid(b_dout_valid), .busy(b_busy),
    .words_sent(b_words_sent)
  );

  always #5 clk = ~clk;

  // Collects payload bits of the MSB-first instance shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (mon_en && a_dout_valid === 1'b1) obs.push_back(a_dout);
  end

  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    return msb ? w[7-i] : w[i];
  endfunction

  function automatic int count_1010(input logic q[$]);
    int n = 0;
    for (int i = 0; i + 3 < q.size(); i++)
      if ({q[i], q[i+1], q[i+2], q[i+3]} == DET_PATTERN) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_dout_valid, a_busy, a_dout} !== 3'b000)
      $display("FAIL reset_outputs: got %b expected 000", {a_dout_valid, a_busy, a_dout});
    else n_pass++;
    n_checks++;
    if (a_words_sent !== 8'd0) $display("FAIL reset_words: got %0d expected 0", a_words_sent);
    else n_pass++;
    n_checks++;
    if ({a_din_ready, b_din_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b expected 00", {a_din_ready, b_din_ready});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_din_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", a_din_ready);
    else n_pass++;
  endtask

  task automatic test_msb_a5();
    logic e;
    @(negedge clk);
    a_din = 8'hA5; a_din_valid = 1'b1;
    @(negedge clk);
    a_din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = exp_bit(8'hA5, i, 1'b1);
      n_checks++;
      if ({a_dout_valid, a_busy, a_dout} !== {2'b11, e})
        $display("FAIL a5_bit%0d: got %b expected %b", i, {a_dout_valid, a_busy, a_dout},
                 {2'b11, e});
      else n_pass++;
      @(negedge clk);
    end
    exp_ws_a++;
    n_checks++;
    if ({a_dout_valid, a_busy, a_dout, a_words_sent} !== {3'b000, exp_ws_a})
      $display("FAIL a5_done: got %b/%0d expected 000/%0d", {a_dout_valid, a_busy, a_dout},
               a_words_sent, exp_ws_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pair;
    pair = 16'hAA55;
    @(negedge clk);
    a_din = 8'hAA; a_din_valid = 1'b1;
    @(negedge clk);
    a_din = 8'h55;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({a_dout_valid, a_dout} !== {1'b1, pair[15-i]})
        $display("FAIL b2b_bit%0d: got %b expected %b", i, {a_dout_valid, a_dout},
                 {1'b1, pair[15-i]});
      else n_pass++;
      if (i == 0 || i == 7) begin
        n_checks++;
        if (a_din_ready !== (i == 7))
          $display("FAIL b2b_ready%0d: got %b expected %b", i, a_din_ready, (i == 7));
        else n_pass++;
      end
      if (i == 8) begin
        a_din_valid = 1'b0;
        n_checks++;
        if (a_words_sent !== exp_ws_a + 8'd1)
          $display("FAIL b2b_mid_words: got %0d expected %0d", a_words_sent, exp_ws_a + 8'd1);
        else n_pass++;
      end
      @(negedge clk);
    end
    exp_ws_a += 8'd2;
    n_checks++;
    if ({a_busy, a_words_sent} !== {1'b0, exp_ws_a})
      $display("FAIL b2b_done: got %b/%0d expected 0/%0d", a_busy, a_words_sent, exp_ws_a);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic e;
    @(negedge clk);
    a_din = 8'hF0; a_din_valid = 1'b1;
    @(negedge clk);
    a_din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = exp_bit(8'hF0, i, 1'b1);
      n_checks++;
      if ({a_dout_valid, a_dout} !== {1'b1, e})
        $display("FAIL stall_pre%0d: got %b expected %b", i, {a_dout_valid, a_dout}, {1'b1, e});
      else n_pass++;
      if (i == 2) a_stall = 1'b1;
      @(negedge clk);
    end
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({a_dout_valid, a_busy, a_dout, a_din_ready} !== 4'b0110)
        $display("FAIL stall_hold%0d: got %b expected 0110", s,
                 {a_dout_valid, a_busy, a_dout, a_din_ready});
      else n_pass++;
      if (s == 1) a_stall = 1'b0;
      @(negedge clk);
    end
    for (int i = 3; i < 8; i++) begin
      e = exp_bit(8'hF0, i, 1'b1);
      n_checks++;
      if ({a_dout_valid, a_dout} !== {1'b1, e})
        $display("FAIL stall_post%0d: got %b expected %b", i, {a_dout_valid, a_dout}, {1'b1, e});
      else n_pass++;
      @(negedge clk);
    end
    exp_ws_a++;
    n_checks++;
    if ({a_busy, a_words_sent} !== {1'b0, exp_ws_a})
      $display("FAIL stall_done: got %b/%0d expected 0/%0d", a_busy, a_words_sent, exp_ws_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic e;
    @(negedge clk);
    a_din = 8'hFF; a_din_valid = 1'b1;
    @(negedge clk);
    a_din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      @(negedge clk);
    end
    exp_ws_a = 8'd0;
    n_checks++;
    if ({a_dout_valid, a_busy, a_dout, a_din_ready, a_words_sent} !== 12'd0)
      $display("FAIL midreset_state: got %b/%0d expected 0000/0",
               {a_dout_valid, a_busy, a_dout, a_din_ready}, a_words_sent);
    else n_pass++;
    rst = 1'b1;
    a_din = 8'h0F; a_din_valid = 1'b1;
    #1;
    n_checks++;
    if (a_din_ready !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", a_din_ready);
    else n_pass++;
    @(negedge clk);
    a_din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = exp_bit(8'h0F, i, 1'b1);
      n_checks++;
      if ({a_dout_valid, a_dout} !== {1'b1, e})
        $display("FAIL midreset_bit%0d: got %b expected %b", i, {a_dout_valid, a_dout},
                 {1'b1, e});
      else n_pass++;
      @(negedge clk);
    end
    exp_ws_a++;
    n_checks++;
    if (a_words_sent !== exp_ws_a)
      $display("FAIL midreset_words: got %0d expected %0d", a_words_sent, exp_ws_a);
    else n_pass++;
  endtask

  task automatic test_lsb();
    logic e;
    @(negedge clk);
    b_din = 8'h0A; b_din_valid = 1'b1;
    @(negedge clk);
    b_din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = exp_bit(8'h0A, i, 1'b0);
      n_checks++;
      if ({b_dout_valid, b_dout} !== {1'b1, e})
        $display("FAIL lsb_bit%0d: got %b expected %b", i, {b_dout_valid, b_dout}, {1'b1, e});
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({b_busy, b_words_sent} !== {1'b0, 8'd1})
      $display("FAIL lsb_done: got %b/%0d expected 0/1", b_busy, b_words_sent);
    else n_pass++;
  endtask

  task automatic test_pattern();
    obs.delete();
    mon_en = 1'b1;
    @(negedge clk);
    a_din = 8'hA0; a_din_valid = 1'b1;
    @(negedge clk);
    a_din_valid = 1'b0;
    repeat (9) @(negedge clk);
    mon_en = 1'b0;
    exp_ws_a++;
    n_checks++;
    if (obs.size() != 8 || count_1010(obs) != 1)
      $display("FAIL pattern_a0: got %0d bits/%0d hits expected 8 bits/1 hit", obs.size(),
               count_1010(obs));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] sent[$];
    logic       expq[$];
    bit         acc;
    int         bad;
    acc = 1'b0;
    obs.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (acc) a_din_valid = 1'b0;
      a_stall = ($urandom_range(3) == 0);
      if (!a_din_valid && $urandom_range(2) != 0) begin
        a_din = 8'($urandom);
        a_din_valid = 1'b1;
        sent.push_back(a_din);
      end
      #1 acc = a_din_valid && a_din_ready;
    end
    for (int c = 0; c < 200 && (a_din_valid || a_busy); c++) begin
      @(negedge clk);
      if (acc) a_din_valid = 1'b0;
      a_stall = 1'b0;
      #1 acc = a_din_valid && a_din_ready;
    end
    @(negedge clk);
    mon_en = 1'b0;
    n_checks++;
    if (a_busy !== 1'b0 || a_din_valid !== 1'b0)
      $display("FAIL rand_drain: got busy=%b pending=%b expected 0/0", a_busy, a_din_valid);
    else n_pass++;
    foreach (sent[k]) for (int i = 0; i < 8; i++) expq.push_back(exp_bit(sent[k], i, 1'b1));
    bad = 0;
    if (obs.size() == expq.size())
      foreach (expq[k]) if (obs[k] !== expq[k]) bad++;
    n_checks++;
    if (obs.size() != expq.size() || bad != 0)
      $display("FAIL rand_stream: got %0d bits (%0d wrong) expected %0d bits", obs.size(), bad,
               expq.size());
    else n_pass++;
    n_checks++;
    if (count_1010(obs) != count_1010(expq))
      $display("FAIL rand_1010: got %0d expected %0d", count_1010(obs), count_1010(expq));
    else n_pass++;
    exp_ws_a += 8'(sent.size());
    n_checks++;
    if (a_words_sent !== exp_ws_a)
      $display("FAIL rand_words: got %0d expected %0d", a_words_sent, exp_ws_a);
    else n_pass++;
  endtask

  initial begin
    a_din = '0; b_din = '0;
    a_din_valid = 1'b0; b_din_valid = 1'b0;
    a_stall = 1'b0; b_stall = 1'b0;
    test_reset();
    test_msb_a5();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_lsb();
    test_pattern();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
